// File: rtl/hwpe_ctrl_loopgen.sv
// Nested-loop index/offset generator: walks up to NB_LOOPS runtime-enabled loop levels
// and streams per-level indices, affine offsets and wrap flags over valid/ready.
module hwpe_ctrl_loopgen #(
    parameter int NB_LOOPS  = 6,
    parameter int NB_REG    = 4,
    parameter int REG_WIDTH = 32,
    parameter int CNT_WIDTH = 12,
    localparam int LW       = $clog2(NB_LOOPS+1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   start_i,
    input  logic [LW-1:0]                          nb_loops_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]          range_i,
    input  logic [NB_LOOPS*NB_REG*REG_WIDTH-1:0]   jump_i,
    input  logic [NB_REG*REG_WIDTH-1:0]            base_i,
    input  logic                                   ready_i,
    output logic                                   valid_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]          idx_o,
    output logic [NB_REG*REG_WIDTH-1:0]            offs_o,
    output logic [NB_LOOPS-1:0]                    last_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    typedef logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]             cnt_arr_t;
    typedef logic [NB_REG-1:0][REG_WIDTH-1:0]               off_arr_t;
    typedef logic [NB_LOOPS-1:0][NB_REG-1:0][REG_WIDTH-1:0] jmp_arr_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e   state_q, state_d;
    logic     done_q, done_d;
    cnt_arr_t idx_q, idx_d;
    cnt_arr_t rmax_q, rmax_d;   // effective range minus one, fixed at start
    jmp_arr_t jmp_q, jmp_d;
    off_arr_t offs_q, offs_d;

    cnt_arr_t            range_in;
    logic [NB_LOOPS-1:0] at_end, last;
    logic [LW-1:0]       nb_eff, lvl;
    off_arr_t            jsel;

    assign range_in = range_i;

    always_comb begin
        at_end = '0;
        last   = '0;
        for (int l = 0; l < NB_LOOPS; l++)
            at_end[l] = (idx_q[l] == rmax_q[l]);
        last[0] = at_end[0];
        for (int l = 1; l < NB_LOOPS; l++)
            last[l] = last[l-1] & at_end[l];
        // lowest level not yet at its end is the one that advances
        lvl = '0;
        for (int l = NB_LOOPS-1; l >= 0; l--)
            if (!at_end[l]) lvl = LW'(l);
        jsel = '0;
        for (int l = 0; l < NB_LOOPS; l++)
            if (LW'(l) == lvl) jsel = jmp_q[l];
        if (nb_loops_i == '0)                  nb_eff = LW'(1);
        else if (int'(nb_loops_i) > NB_LOOPS)  nb_eff = LW'(NB_LOOPS);
        else                                   nb_eff = nb_loops_i;
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
        offs_d  = offs_q;
        rmax_d  = rmax_q;
        jmp_d   = jmp_q;
        if (clear_i) begin
            state_d = IDLE;
            idx_d   = '0;
            offs_d  = '0;
            rmax_d  = '0;
            jmp_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = RUN;
                        idx_d   = '0;
                        offs_d  = base_i;
                        jmp_d   = jump_i;
                        // disabled levels and zero ranges both collapse to a single iteration
                        for (int l = 0; l < NB_LOOPS; l++)
                            rmax_d[l] = (l < int'(nb_eff) && range_in[l] != '0) ?
                                        range_in[l] - CNT_WIDTH'(1) : '0;
                    end
                end
                RUN: begin
                    if (ready_i) begin
                        if (last[NB_LOOPS-1]) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            for (int l = 0; l < NB_LOOPS; l++) begin
                                if (LW'(l) < lvl)       idx_d[l] = '0;
                                else if (LW'(l) == lvl) idx_d[l] = idx_q[l] + CNT_WIDTH'(1);
                            end
                            for (int r = 0; r < NB_REG; r++)
                                offs_d[r] = offs_q[r] + jsel[r];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            idx_q   <= '0;
            offs_q  <= '0;
            rmax_q  <= '0;
            jmp_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            offs_q  <= offs_d;
            rmax_q  <= rmax_d;
            jmp_q   <= jmp_d;
        end
    end

    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign done_o  = done_q;
    assign idx_o   = idx_q;
    assign offs_o  = offs_q;
    assign last_o  = valid_o ? last : '0;

endmodule

// File: tb/tb_hwpe_ctrl_loopgen.sv
// Bench for hwpe_ctrl_loopgen: config table runs scored against a mixed-radix reference,
// plus stall, mid-run start, clear, back-to-back start and async reset sequences.
module tb_hwpe_ctrl_loopgen;

    logic              clk = 1'b0;
    logic              rst_ni, clear_i, start_i, ready_i;
    logic [2:0]        nb_loops_i;
    logic [71:0]       range_i;
    logic [767:0]      jump_i;
    logic [127:0]      base_i;
    logic              valid_o, busy_o, done_o;
    logic [71:0]       idx_o;
    logic [127:0]      offs_o;
    logic [5:0]        last_o;

    hwpe_ctrl_loopgen dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .nb_loops_i(nb_loops_i), .range_i(range_i), .jump_i(jump_i), .base_i(base_i),
        .ready_i(ready_i), .valid_o(valid_o), .idx_o(idx_o), .offs_o(offs_o),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]              nb;
        logic [5:0][11:0]        rng;
        logic [3:0][31:0]        base;
        logic [5:0][3:0][31:0]   jmp;
        logic                    rnd;
    } vec_t;

    typedef struct packed {
        logic [5:0][11:0]  idx;
        logic [3:0][31:0]  offs;
        logic [5:0]        last;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    // reference: beat k's index is the mixed-radix digit expansion of k
    task automatic push_model(input vec_t v);
        int eff[6];
        int pre[6];
        int nbe, total, lv;
        exp_t e;
        logic [3:0][31:0] o;
        nbe = (v.nb == 0) ? 1 : (v.nb > 6) ? 6 : int'(v.nb);
        total = 1;
        for (int l = 0; l < 6; l++) begin
            eff[l] = (l < nbe) ? ((v.rng[l] == 0) ? 1 : int'(v.rng[l])) : 1;
            pre[l] = total;
            total  = total * eff[l];
        end
        o = v.base;
        for (int k = 0; k < total; k++) begin
            e = '0;
            for (int l = 0; l < 6; l++) begin
                e.idx[l]  = 12'((k / pre[l]) % eff[l]);
                e.last[l] = ((k + 1) % (pre[l] * eff[l])) == 0;
            end
            e.offs = o;
            sb.push_back(e);
            lv = 0;
            for (int l = 5; l >= 0; l--)
                if ((k / pre[l]) % eff[l] != eff[l] - 1) lv = l;
            for (int r = 0; r < 4; r++) o[r] = o[r] + v.jmp[lv][r];
        end
    endtask

    // caller is at a negedge; returns at a negedge
    task automatic run_vec(input vec_t v, input int stall_at, input int poke_at,
                           input int clear_at, input bit chain);
        exp_t e;
        int beats = 0, stall = 0, cyc = 0;
        bit fin = 0, poked = 0;
        sb.delete();
        push_model(v);
        nb_loops_i = v.nb; range_i = v.rng; jump_i = v.jmp; base_i = v.base;
        ready_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_latency", valid_o, 1);
        while (!fin) begin
            cyc++;
            if (cyc > 2000) begin
                chk("timeout", 0, 1);
                fin = 1;
            end else if (beats == clear_at) begin
                clear_i = 1'b1; ready_i = 1'b1;
                @(negedge clk);
                clear_i = 1'b0; ready_i = 1'b0;
                chk("clear_valid", valid_o, 0);
                chk("clear_outs", {idx_o, offs_o, last_o, busy_o}, 0);
                chk("clear_done", done_o, 0);
                @(negedge clk);
                chk("clear_no_done", done_o, 0);
                fin = 1;
            end else begin
                start_i = 1'b0;
                if (beats == stall_at && stall < 3) begin
                    ready_i = 1'b0;
                    stall++;
                    chk("stall_valid", valid_o, 1);
                end else begin
                    ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (beats == poke_at && !poked) begin
                    poked = 1;
                    start_i = 1'b1;
                    base_i = '1; range_i = '0; nb_loops_i = 3'd1;
                end
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        chk("extra_beat", 1, 0);
                        fin = 1;
                    end else begin
                        e = sb.pop_front();
                        chk("idx", idx_o, e.idx);
                        chk("offs", offs_o, e.offs);
                        chk("last", last_o, e.last);
                        beats++;
                        if (e.last[5]) begin
                            @(negedge clk);
                            ready_i = 1'b0; start_i = 1'b0;
                            chk("done", done_o, 1);
                            chk("idle_valid", valid_o, 0);
                            chk("hold_offs", offs_o, e.offs);
                            chk("hold_idx", idx_o, e.idx);
                            if (chain) begin
                                start_i = 1'b1;
                                @(negedge clk);
                                start_i = 1'b0;
                                chk("chain_valid", valid_o, 1);
                                chk("chain_offs", offs_o, v.base);
                                chk("chain_idx", idx_o, 0);
                                clear_i = 1'b1;
                                @(negedge clk);
                                clear_i = 1'b0;
                            end else begin
                                @(negedge clk);
                                chk("done_pulse", done_o, 0);
                            end
                            fin = 1;
                        end
                    end
                end
                if (!fin) @(negedge clk);
            end
        end
        start_i = 1'b0; ready_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        nb_loops_i = '0; range_i = '0; jump_i = '0; base_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_done_busy", {done_o, busy_o}, 0);
        chk("rst_outs", {idx_o, offs_o, last_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) tbl[i] = '0;
        tbl[0].nb = 3'd2; tbl[0].rng[0] = 12'd3; tbl[0].rng[1] = 12'd2;
        tbl[0].base[0] = 32'd100; tbl[0].jmp[0][0] = 32'd4; tbl[0].jmp[1][0] = 32'd92;
        tbl[1].nb = 3'd2; tbl[1].base[0] = 32'd55; tbl[1].base[1] = 32'd7;
        tbl[1].jmp[0][0] = 32'd9; tbl[1].jmp[1][1] = 32'd3;
        tbl[2].nb = 3'd1; tbl[2].rng[0] = 12'd2;
        tbl[2].base[0] = 32'hFFFF_FFFC; tbl[2].jmp[0][0] = 32'd8;
        tbl[3].nb = 3'd1; tbl[3].rng[0] = 12'd4; tbl[3].rng[1] = 12'd5;
        tbl[3].base[2] = 32'd10; tbl[3].jmp[0][2] = 32'd3; tbl[3].jmp[1][2] = 32'd1000;
        tbl[4].nb = 3'd3; tbl[4].rng[0] = 12'd2; tbl[4].rng[1] = 12'd3; tbl[4].rng[2] = 12'd2;
        tbl[4].base[1] = 32'd1000; tbl[4].jmp[0][1] = -32'sd5; tbl[4].jmp[1][1] = -32'sd20;
        tbl[4].jmp[2][1] = 32'd500; tbl[4].jmp[2][3] = 32'd1; tbl[4].rnd = 1'b1;
        tbl[5].nb = 3'd0; tbl[5].rng[0] = 12'd3; tbl[5].rng[1] = 12'd9;
        tbl[5].base[3] = 32'd1; tbl[5].jmp[0][3] = 32'd2; tbl[5].rnd = 1'b1;
        tbl[6].nb = 3'd7;
        tbl[6].rng[0] = 12'd2; tbl[6].rng[2] = 12'd2; tbl[6].rng[4] = 12'd2; tbl[6].rng[5] = 12'd3;
        for (int l = 0; l < 6; l++)
            for (int r = 0; r < 4; r++) tbl[6].jmp[l][r] = 32'((l + 1) * 16 + r);
        tbl[6].rnd = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], -1, -1, -1, 1'b0);
            if (i == 0) begin
                chk("t1_final_offs0", offs_o[31:0], 32'd208);
                chk("t1_final_idx0", idx_o[11:0], 12'd2);
            end
        end

        run_vec(tbl[0], 1, -1, -1, 1'b0);   // stall on the second beat
        run_vec(tbl[0], -1, 1, 3, 1'b0);    // stray start, then clear at beat 3
        run_vec(tbl[2], -1, -1, -1, 1'b1);  // restart on the done cycle

        nb_loops_i = tbl[3].nb; range_i = tbl[3].rng; jump_i = tbl[3].jmp; base_i = tbl[3].base;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", {valid_o, busy_o, done_o}, 0);
        chk("async_rst_outs", {idx_o, offs_o, last_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1; ready_i = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
